// File: rtl/router_out_arb.sv
// router_out_arb -- packet-locking round-robin output arbiter.
//
// Picks one of NREQ requesters and holds the grant until that requester
// passes a tail flit. Accepted flits go into a single output register, so
// they appear one cycle after acceptance. The register can drain and reload
// in the same cycle, which sustains one flit per cycle.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low
//   in_valid   [NREQ]        per-requester flit valid
//   in_data    [NREQ*WIDTH]  requester i at [i*WIDTH +: WIDTH]
//   in_last    [NREQ]        per-requester tail marker
//   in_ready   [NREQ]        per-requester accept, at most one bit set
//   out_valid  output flit valid
//   out_data   [WIDTH] output flit
//   out_last   output tail marker
//   out_ready  downstream accept
//   grant      [NREQ] one-hot current owner, 0 when idle
//   busy       high while LOCKED

// Per-requester lane. It gates ready with ownership and masks the flit so
// the top level can merge all lanes with a plain OR.
module router_out_arb_lane #(
  parameter int WIDTH = 11
) (
  input  logic             own,
  input  logic             slot_free,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             ready,
  output logic             xfer,
  output logic [WIDTH-1:0] sel_data,
  output logic             sel_last
);
  assign ready    = own & slot_free;
  assign xfer     = ready & in_valid;
  assign sel_data = xfer ? in_data : '0;
  assign sel_last = xfer & in_last;
endmodule

module router_out_arb #(
  parameter int WIDTH = 11,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       in_valid,
  input  logic [NREQ*WIDTH-1:0] in_data,
  input  logic [NREQ-1:0]       in_last,
  output logic [NREQ-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [NREQ-1:0]       grant,
  output logic                  busy
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  typedef struct packed {
    logic             last;
    logic [WIDTH-1:0] data;
  } flit_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   own_idx;
  logic [NREQ-1:0] grant_q;
  logic            busy_q;
  logic            out_vld;
  flit_t           out_q;

  // Lane fabric
  logic                       slot_free;
  logic [NREQ-1:0]            lane_own;
  logic [NREQ-1:0]            lane_ready;
  logic [NREQ-1:0]            lane_xfer;
  logic [NREQ-1:0][WIDTH-1:0] lane_data;
  logic [NREQ-1:0]            lane_last;

  // The output slot can take a flit when it is empty or is draining this cycle.
  assign slot_free = !out_vld || out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_lane
      // Ownership is dropped while reset is low so in_ready is 0 right away.
      assign lane_own[gi] = reset && (state == LOCKED) && grant_q[gi];
      router_out_arb_lane #(.WIDTH(WIDTH)) u_lane (
        .own       (lane_own[gi]),
        .slot_free (slot_free),
        .in_valid  (in_valid[gi]),
        .in_data   (in_data[gi*WIDTH +: WIDTH]),
        .in_last   (in_last[gi]),
        .ready     (lane_ready[gi]),
        .xfer      (lane_xfer[gi]),
        .sel_data  (lane_data[gi]),
        .sel_last  (lane_last[gi])
      );
    end
  endgenerate

  // Only the owner's lane can be non-zero, so an OR merge is the mux.
  logic             acc;
  logic             tail;
  logic [WIDTH-1:0] acc_data;

  always_comb begin
    acc_data = '0;
    for (int i = 0; i < NREQ; i++) acc_data |= lane_data[i];
  end

  assign acc  = |lane_xfer;
  assign tail = |lane_last;

  // Round-robin search that starts at ptr and wraps modulo NREQ.
  logic          sel_found;
  logic [PW-1:0] sel_idx;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!sel_found && in_valid[idx]) begin
        sel_found = 1'b1;
        sel_idx   = PW'(idx);
      end
    end
  end

  logic [PW-1:0] ptr_nxt;
  assign ptr_nxt = (int'(own_idx) == NREQ - 1) ? '0 : own_idx + PW'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      ptr     <= '0;
      own_idx <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      out_vld <= 1'b0;
      out_q   <= '0;
    end else begin
      // Output register: load wins over drain so that drain and load can
      // happen in the same cycle. It holds while stalled.
      if (acc) begin
        out_q.data <= acc_data;
        out_q.last <= tail;
        out_vld    <= 1'b1;
      end else if (out_ready) begin
        out_vld <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (sel_found) begin
            state   <= LOCKED;
            own_idx <= sel_idx;
            grant_q <= NREQ'(1) << sel_idx;
            busy_q  <= 1'b1;
          end
        end
        LOCKED: begin
          // Only a tail flit that is accepted releases the lock. The owner
          // may drop in_valid and we keep waiting.
          if (tail) begin
            state   <= IDLE;
            ptr     <= ptr_nxt;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = lane_ready;
  assign out_valid = out_vld;
  assign out_data  = out_q.data;
  assign out_last  = out_q.last;
  assign grant     = grant_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_router_out_arb.sv
module tb_router_out_arb;
  localparam int WIDTH = 11;
  localparam int NREQ  = 4;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       in_valid;
  logic [NREQ*WIDTH-1:0] in_data;
  logic [NREQ-1:0]       in_last;
  logic [NREQ-1:0]       in_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic                  out_last;
  logic                  out_ready;
  logic [NREQ-1:0]       grant;
  logic                  busy;

  int n_chk = 0;
  int n_fail = 0;

  router_out_arb #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .grant     (grant),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; drive and sample happen 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_lane(input int i, input logic v, input logic [WIDTH-1:0] d,
                          input logic l);
    in_valid[i]              = v;
    in_data[i*WIDTH +: WIDTH] = d;
    in_last[i]               = l;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    in_last   = '0;
    out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    settle();
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    in_valid  = '1;
    in_data   = '1;
    in_last   = '0;
    out_ready = 1'b1;
    tick();
    tick();
    n_chk++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
    n_chk++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_chk++; if (out_data !== 11'h000) begin n_fail++; $display("FAIL reset_out_data: got %h want 000", out_data); end
    n_chk++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    in_valid = '0;
    in_data  = '0;
    reset    = 1'b1;
    settle();
  endtask

  task automatic test_packet();
    do_reset();
    set_lane(2, 1'b1, 11'h011, 1'b0);
    tick();
    n_chk++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL pkt_grant: got %b want 0100", grant); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pkt_busy: got %b want 1", busy); end
    n_chk++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL pkt_in_ready: got %b want 0100", in_ready); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pkt_pre_out_valid: got %b want 0", out_valid); end
    tick();
    n_chk++; if (out_valid !== 1'b1 || out_data !== 11'h011 || out_last !== 1'b0) begin n_fail++; $display("FAIL pkt_flit0: got v%b %h l%b want v1 011 l0", out_valid, out_data, out_last); end
    set_lane(2, 1'b1, 11'h022, 1'b0);
    tick();
    n_chk++; if (out_valid !== 1'b1 || out_data !== 11'h022 || out_last !== 1'b0) begin n_fail++; $display("FAIL pkt_flit1: got v%b %h l%b want v1 022 l0", out_valid, out_data, out_last); end
    set_lane(2, 1'b1, 11'h433, 1'b1);
    tick();
    n_chk++; if (out_valid !== 1'b1 || out_data !== 11'h433 || out_last !== 1'b1) begin n_fail++; $display("FAIL pkt_flit2: got v%b %h l%b want v1 433 l1", out_valid, out_data, out_last); end
    n_chk++; if (grant !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL pkt_release: got g%b b%b want g0000 b0", grant, busy); end
    // ptr is now 3: with requesters 0 and 3 pending, 3 must win.
    set_lane(2, 1'b0, 11'h000, 1'b0);
    set_lane(0, 1'b1, 11'h0AA, 1'b1);
    set_lane(3, 1'b1, 11'h0BB, 1'b1);
    tick();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pkt_drain: got %b want 0", out_valid); end
    n_chk++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL pkt_ptr3: got %b want 1000", grant); end
    tick();
    n_chk++; if (out_data !== 11'h0BB || out_last !== 1'b1) begin n_fail++; $display("FAIL pkt_ptr3_flit: got %h l%b want 0bb l1", out_data, out_last); end
    in_valid = '0;
  endtask

  task automatic test_round_robin();
    logic [WIDTH-1:0] exp_d;
    logic [NREQ-1:0]  exp_g;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_lane(i, 1'b1, WIDTH'(11'h100 + i), 1'b1);
    for (int g = 0; g < 5; g++) begin
      exp_g = 4'b0001 << (g % 4);
      exp_d = WIDTH'(11'h100 + (g % 4));
      tick();
      n_chk++; if (grant !== exp_g) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", g, grant, exp_g); end
      tick();
      n_chk++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rr_idle%0d: got %b want 0000", g, grant); end
      n_chk++; if (out_valid !== 1'b1 || out_data !== exp_d || out_last !== 1'b1) begin n_fail++; $display("FAIL rr_flit%0d: got v%b %h l%b want v1 %h l1", g, out_valid, out_data, out_last, exp_d); end
    end
    in_valid = '0;
  endtask

  task automatic test_stall();
    do_reset();
    out_ready = 1'b0;
    set_lane(1, 1'b1, 11'h155, 1'b0);
    tick();
    n_chk++; if (grant !== 4'b0010 || in_ready !== 4'b0010) begin n_fail++; $display("FAIL stall_grant: got g%b r%b want g0010 r0010", grant, in_ready); end
    tick();
    set_lane(1, 1'b1, 11'h1AA, 1'b1);
    settle();
    for (int c = 0; c < 5; c++) begin
      n_chk++; if (out_valid !== 1'b1 || out_data !== 11'h155) begin n_fail++; $display("FAIL stall_hold%0d: got v%b %h want v1 155", c, out_valid, out_data); end
      n_chk++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_ready%0d: got %b want 0000", c, in_ready); end
      tick();
    end
    out_ready = 1'b1;
    settle();
    n_chk++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL stall_unblock: got %b want 0010", in_ready); end
    tick();
    n_chk++; if (out_valid !== 1'b1 || out_data !== 11'h1AA || out_last !== 1'b1) begin n_fail++; $display("FAIL stall_next: got v%b %h l%b want v1 1aa l1", out_valid, out_data, out_last); end
    in_valid = '0;
    tick();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_owner_drop();
    do_reset();
    set_lane(2, 1'b1, 11'h201, 1'b0);
    tick();
    tick();
    n_chk++; if (out_data !== 11'h201) begin n_fail++; $display("FAIL drop_flit0: got %h want 201", out_data); end
    set_lane(2, 1'b0, 11'h000, 1'b0);
    set_lane(0, 1'b1, 11'h0F0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_chk++; if (grant !== 4'b0100 || busy !== 1'b1) begin n_fail++; $display("FAIL drop_hold%0d: got g%b b%b want g0100 b1", c, grant, busy); end
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drop_novalid%0d: got %b want 0", c, out_valid); end
    end
    set_lane(2, 1'b1, 11'h202, 1'b0);
    tick();
    set_lane(2, 1'b1, 11'h203, 1'b1);
    tick();
    n_chk++; if (out_data !== 11'h203 || out_last !== 1'b1 || grant !== 4'b0000) begin n_fail++; $display("FAIL drop_tail: got %h l%b g%b want 203 l1 g0000", out_data, out_last, grant); end
    set_lane(2, 1'b0, 11'h000, 1'b0);
    tick();
    n_chk++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL drop_next: got %b want 0001", grant); end
    tick();
    n_chk++; if (out_data !== 11'h0F0) begin n_fail++; $display("FAIL drop_next_flit: got %h want 0f0", out_data); end
    in_valid = '0;
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    out_ready = 1'b0;
    set_lane(2, 1'b1, 11'h3AB, 1'b0);
    tick();
    tick();
    n_chk++; if (out_valid !== 1'b1 || out_data !== 11'h3AB) begin n_fail++; $display("FAIL mid_loaded: got v%b %h want v1 3ab", out_valid, out_data); end
    out_ready = 1'b1;
    reset = 1'b0;
    settle();
    n_chk++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_comb_ready: got %b want 0000", in_ready); end
    tick();
    n_chk++; if (out_valid !== 1'b0 || grant !== 4'b0000 || busy !== 1'b0 || out_data !== 11'h000) begin n_fail++; $display("FAIL mid_cleared: got v%b g%b b%b %h want v0 g0000 b0 000", out_valid, grant, busy, out_data); end
    reset = 1'b1;
    in_valid = '0;
    set_lane(1, 1'b1, 11'h011, 1'b1);
    set_lane(3, 1'b1, 11'h033, 1'b1);
    tick();
    n_chk++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL mid_resume: got %b want 0010", grant); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_xfer: got %b want 0", out_valid); end
    in_valid = '0;
    tick();
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    in_last   = '0;
    out_ready = 1'b1;
    test_reset();
    test_packet();
    test_round_robin();
    test_stall();
    test_owner_drop();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
